// File: rtl/serial_tx_scheduler_pkg.sv
// rtl/serial_tx_scheduler_pkg.sv - shared FSM state type and default parameters for serial_tx_scheduler
package serial_tx_scheduler_pkg;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_GAP_CYCLES  = 16;
    localparam int DEF_ACK_TIMEOUT = 4096;

    localparam int TMO_W = 16;
    localparam int GAP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - requester arbiter, round-robin by default, fixed priority with TX_FIXED_PRIORITY_EN
//
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   req          request vector, one bit per requester
//   advance      strobe: the current grant was taken, move the round-robin pointer
//   grant        one-hot grant (all zero when no request)
//   grant_idx    binary index of the granted requester
//   grant_valid  high when any requester is granted
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

`ifdef TX_FIXED_PRIORITY_EN

    // Lowest index wins; no pointer state is kept.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[IDX_W'(i)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

    logic unused_fixed;
    assign unused_fixed = ^{clk, rst, advance};

`else

    logic [IDX_W-1:0] last;
    int               cand;

    // Search starts one past the last winner and wraps, so the last winner
    // is considered only when nobody else is asking.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_valid && req[IDX_W'(cand)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= IDX_W'(NUM_REQ - 1);
        end else if (advance && grant_valid) begin
            last <= grant_idx;
        end
    end

`endif

    always_comb begin
        grant = '0;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx_scheduler.sv
// rtl/serial_tx_scheduler.sv - arbitrates byte requesters onto a single handshake toward avr_interface
//
// Optional feature macro: TX_FIXED_PRIORITY_EN (fixed lowest-index-wins arbitration).
//
// Ports:
//   clk_dot4x    sole clock (4x dot clock)
//   rst          asynchronous active-high reset
//   req_valid    per-requester byte pending, held until req_ack
//   req_data     requester i byte at [8i+7:8i]
//   req_ack      one-cycle acceptance pulse, at most one bit set
//   tx_data      byte presented to avr_interface, stable while tx_new_data is high
//   tx_new_data  level request, held until tx_busy acknowledges it
//   tx_busy      asynchronous busy flag from avr_interface
//   timeout_err  sticky, set when tx_busy never acknowledges a byte
//   idle         high only while the scheduler is in IDLE
module serial_tx_scheduler
    import serial_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                 clk_dot4x,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           tx_data,
    output logic                 tx_new_data,
    input  logic                 tx_busy,
    output logic                 timeout_err,
    output logic                 idle
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
    localparam logic [GAP_W:0]   GAP_LEN  = (GAP_W + 1)'(GAP_CYCLES);

    (* ASYNC_REG = "TRUE" *) logic busy_meta;
    (* ASYNC_REG = "TRUE" *) logic busy_s;

    tx_state_t          state;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               accept;
    logic [7:0]         sel_byte;
    logic               gap_done;

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            busy_meta <= 1'b0;
            busy_s    <= 1'b0;
        end else begin
            busy_meta <= tx_busy;
            busy_s    <= busy_meta;
        end
    end

    // A new byte is only taken while the interface is not still busy.
    assign accept   = (state == ST_IDLE) && grant_valid && !busy_s;
    assign sel_byte = req_data[{grant_idx, 3'b000} +: 8];
    // GAP_CYCLES of 0 still spends the one cycle it takes to leave GAP.
    assign gap_done = ({1'b0, gap_cnt} + (GAP_W + 1)'(1)) >= GAP_LEN;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .clk         (clk_dot4x),
        .rst         (rst),
        .req         (req_valid),
        .advance     (accept),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            tx_new_data <= 1'b0;
            tx_data     <= 8'h00;
            req_ack     <= '0;
            timeout_err <= 1'b0;
            idle        <= 1'b1;
            tmo_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            req_ack <= '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data     <= sel_byte;
                        req_ack     <= grant;
                        tx_new_data <= 1'b1;
                        idle        <= 1'b0;
                        state       <= ST_SEND;
                        tmo_cnt     <= '0;
                        gap_cnt     <= '0;
                    end
                end
                ST_SEND: begin
                    if (busy_s) begin
                        tx_new_data <= 1'b0;
                        state       <= ST_DRAIN;
                        tmo_cnt     <= '0;
                        gap_cnt     <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Interface never answered: drop the byte.
                        timeout_err <= 1'b1;
                        tx_new_data <= 1'b0;
                        state       <= ST_GAP;
                        tmo_cnt     <= '0;
                        gap_cnt     <= '0;
                    end else if (tmo_cnt != '1) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!busy_s) begin
                        state   <= ST_GAP;
                        tmo_cnt <= '0;
                        gap_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_done) begin
                        state   <= ST_IDLE;
                        idle    <= 1'b1;
                        tmo_cnt <= '0;
                        gap_cnt <= '0;
                    end else if (gap_cnt != '1) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    idle        <= 1'b1;
                    tx_new_data <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb/tb_serial_tx_scheduler.sv - scoreboard bench for serial_tx_scheduler
module tb_serial_tx_scheduler;

    localparam int N   = 4;
    localparam int GAP = 16;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic [7:0]     tx_data;
    logic           tx_new_data;
    logic           tx_busy;
    logic           timeout_err;
    logic           idle;

    logic resp_busy  = 1'b0;
    logic busy_force = 1'b0;
    logic resp_en    = 1'b0;
    assign tx_busy = resp_busy | busy_force;

    always #5 clk = ~clk;

    serial_tx_scheduler #(
        .NUM_REQ     (N),
        .GAP_CYCLES  (GAP),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk_dot4x   (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .tx_new_data (tx_new_data),
        .tx_busy     (tx_busy),
        .timeout_err (timeout_err),
        .idle        (idle)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   model_last = N - 1;
    bit   contin = 1'b0;
    int   seq[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration: who wins among the pending set.
    function automatic int model_pick(input logic [N-1:0] m);
`ifdef TX_FIXED_PRIORITY_EN
        for (int i = 0; i < N; i++) if (m[i]) return i;
`else
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (model_last + k) % N;
            if (m[c]) return c;
        end
`endif
        return -1;
    endfunction

    // All requesters in m held together: grants come one at a time in arbitration order.
    task automatic expect_grants(input logic [N-1:0] m);
        int i;
        while (m != '0) begin
            i = model_pick(m);
            sb.push_back('{i, req_data[8*i +: 8]});
            model_last = i;
            m[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) begin
                if (contin) begin
                    seq[i]++;
                    req_data[8*i +: 8] = 8'(i * 16 + seq[i]);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (idle !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        if (idle !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: idle=%b after %0d cycles, required 1", idle, n);
        end
    endtask

    // Monitor: every ack is compared against the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && req_ack != '0) begin
            check("ack_onehot", $countones(req_ack), 1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got req_ack=%b, required no ack", req_ack);
            end else begin
                mon_e = sb.pop_front();
                check("ack_idx", 32'(req_ack), 32'(1) << mon_e.idx);
                check("ack_data", 32'(tx_data), 32'(mon_e.data));
                check("ack_new_data", 32'(tx_new_data), 1);
            end
        end
    end

    // avr_interface stand-in: raise busy some cycles after tx_new_data, then release.
    initial begin
        int d, h, n;
        forever begin
            @(negedge clk);
            if (resp_en && !rst && tx_new_data) begin
                d = $urandom_range(0, 2);
                repeat (d) @(negedge clk);
                resp_busy = 1'b1;
                h = $urandom_range(3, 6);
                repeat (h) @(negedge clk);
                resp_busy = 1'b0;
                n = 0;
                while (tx_new_data && n < 50) begin
                    @(negedge clk);
                    n++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks, n, nack;
        int mseq[N];
        logic [N-1:0] m;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_new_data", 32'(tx_new_data), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_ack", 32'(req_ack), 0);
        check("rst_timeout", 32'(timeout_err), 0);
        check("rst_idle", 32'(idle), 1);
        rst = 1'b0;
        tick();

        // Single request, busy echoed 3 cycles after tx_new_data
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        expect_grants(4'b0001);
        tick();
        check("single_latency", 32'(tx_new_data), 1);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_ack", 32'(req_ack), 32'b0001);
        tick();
        check("single_ack_pulse", 32'(req_ack), 0);
        check("single_data_stable", 32'(tx_data), 32'hA5);
        repeat (2) tick();
        busy_force = 1'b1;
        repeat (4) tick();
        check("drain_new_data", 32'(tx_new_data), 0);
        busy_force = 1'b0;
        repeat (18) tick();
        check("gap_not_idle", 32'(idle), 0);
        tick();
        check("gap_idle", 32'(idle), 1);
        check("single_no_timeout", 32'(timeout_err), 0);

        // Contention from reset, all requesters valid continuously
        rst = 1'b1;
        model_last = N - 1;
        tick();
        rst = 1'b0;
        resp_en = 1'b1;
        contin = 1'b1;
        for (int i = 0; i < N; i++) begin
            seq[i] = 0;
            mseq[i] = 0;
            req_data[8*i +: 8] = 8'(i * 16);
        end
        for (int k = 0; k < 5; k++) begin
            int w;
            w = model_pick('1);
            sb.push_back('{w, 8'(w * 16 + mseq[w])});
            mseq[w]++;
            model_last = w;
        end
        req_valid = '1;
        acks = 0;
        n = 0;
        while (acks < 5 && n < 2000) begin
            tick();
            if (req_ack != '0) acks++;
            n++;
        end
        contin = 1'b0;
        req_valid = '0;
        check("contention_acks", acks, 5);
        wait_idle();

        // Acknowledge timeout
        resp_en = 1'b0;
        req_data[15:8] = 8'($urandom);
        req_valid[1] = 1'b1;
        expect_grants(4'b0010);
        tick();
        check("to_new_data", 32'(tx_new_data), 1);
        repeat (7) tick();
        check("to_err_early", 32'(timeout_err), 0);
        check("to_still_send", 32'(tx_new_data), 1);
        tick();
        check("to_err", 32'(timeout_err), 1);
        check("to_dropped", 32'(tx_new_data), 0);
        check("to_not_idle", 32'(idle), 0);
        repeat (15) tick();
        check("to_gap", 32'(idle), 0);
        tick();
        check("to_idle", 32'(idle), 1);
        check("to_sticky", 32'(timeout_err), 1);

        // Reset while in SEND
        req_data[23:16] = 8'($urandom);
        req_valid[2] = 1'b1;
        expect_grants(4'b0100);
        tick();
        check("rs_in_send", 32'(tx_new_data), 1);
        #2 rst = 1'b1;
        #1;
        check("rs_new_data", 32'(tx_new_data), 0);
        check("rs_tx_data", 32'(tx_data), 0);
        check("rs_ack", 32'(req_ack), 0);
        check("rs_timeout", 32'(timeout_err), 0);
        check("rs_idle", 32'(idle), 1);
        model_last = N - 1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) tick();
        check("rs_stays_idle", 32'(idle), 1);

        // Busy already high when the request arrives
        resp_en = 1'b1;
        busy_force = 1'b1;
        repeat (3) tick();
        req_data[15:8] = 8'($urandom);
        req_valid[1] = 1'b1;
        expect_grants(4'b0010);
        nack = 0;
        repeat (4) begin
            tick();
            if (req_ack != '0) nack++;
        end
        check("busy_no_ack", nack, 0);
        busy_force = 1'b0;
        tick();
        check("busy_ack_c1", 32'(req_ack), 0);
        tick();
        check("busy_ack_c2", 32'(req_ack), 0);
        tick();
        check("busy_ack_c3", 32'(req_ack), 32'b0010);
        wait_idle();

        // Withdrawn request: requester 2 drops before any grant
        busy_force = 1'b1;
        repeat (3) tick();
        req_data[23:16] = 8'($urandom);
        req_data[31:24] = 8'($urandom);
        req_valid[3:2] = 2'b11;
        repeat (2) tick();
        req_valid[2] = 1'b0;
        expect_grants(4'b1000);
        tick();
        busy_force = 1'b0;
        n = 0;
        while (req_valid[3] && n < 200) begin
            tick();
            n++;
        end
        check("wd_acked", 32'(req_valid), 0);
        wait_idle();

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            wait_idle();
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (m[i]) req_data[8*i +: 8] = 8'($urandom);
            end
            expect_grants(m);
            req_valid = m;
            n = 0;
            while (req_valid != '0 && n < 3000) begin
                tick();
                n++;
            end
            check("rnd_drained", 32'(req_valid), 0);
        end
        wait_idle();
        repeat (5) tick();
        check("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
